// File: rtl/ln_stream_pkg.sv
// Shared types and sizing for the LayerNorm streaming path.
package ln_stream_pkg;

  localparam int D_MODEL    = 64;
  localparam int DATA_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CSUM = 2'd2
  } ser_state_e;

endpackage

// File: rtl/ln_result_serializer.sv
// Captures one flat LayerNorm result vector and replays it as a valid/ready
// word stream, optionally followed by an additive checksum word.
//
// state | meaning
// IDLE  | waiting for a frame; result_ready high
// DATA  | emitting buffered word[idx], advancing on each handshake
// CSUM  | emitting the accumulated checksum as the last word
module ln_result_serializer
  import ln_stream_pkg::ser_state_e;
  import ln_stream_pkg::IDLE;
  import ln_stream_pkg::DATA;
  import ln_stream_pkg::CSUM;
#(
  parameter int D_MODEL     = ln_stream_pkg::D_MODEL,
  parameter int DATA_WIDTH  = ln_stream_pkg::DATA_WIDTH,
  parameter int APPEND_CSUM = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          result_valid,
  input  logic [D_MODEL*DATA_WIDTH-1:0] result_in,
  output logic                          result_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_word,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          drop_pulse,
  output logic [7:0]                    frame_cnt
);

  localparam int                IDX_W    = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(D_MODEL - 1);
  localparam bit                HAS_CSUM = (APPEND_CSUM != 0);
  localparam bit                ONE_WORD = (D_MODEL == 1);

  ser_state_e                    state_q, state_d;
  logic [D_MODEL*DATA_WIDTH-1:0] frame_q;
  logic [IDX_W-1:0]              idx_q, idx_inc;
  logic [DATA_WIDTH-1:0]         acc_q, acc_sum, next_word;
  logic [DATA_WIDTH-1:0]         out_word_q;
  logic                          out_valid_q, out_last_q, drop_q;
  logic [7:0]                    frame_cnt_q;
  logic                          accept, hs, at_last;

  assign accept  = (state_q == IDLE) && result_valid;
  assign hs      = out_valid_q && out_ready;
  assign at_last = (idx_q == LAST_IDX);
  assign acc_sum = acc_q + out_word_q;
  assign idx_inc = at_last ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DATA;
      DATA:    if (hs && at_last) state_d = HAS_CSUM ? CSUM : IDLE;
      CSUM:    if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame buffer is loaded only on accept; the index mux looks one word ahead
  // so the output register can be refilled on the handshake edge.
  always_ff @(posedge clk) begin
    if (accept) frame_q <= result_in;
  end

  always_comb begin
    next_word = frame_q[int'(idx_inc)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_last_q  <= 1'b0;
      drop_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      drop_q <= result_valid && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b1;
            out_word_q  <= result_in[DATA_WIDTH-1:0];
            out_last_q  <= ONE_WORD && !HAS_CSUM;
          end
        end
        DATA: begin
          if (hs) begin
            acc_q <= acc_sum;
            if (at_last) begin
              if (HAS_CSUM) begin
                out_word_q <= acc_sum;
                out_last_q <= 1'b1;
              end else begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                frame_cnt_q <= frame_cnt_q + 8'd1;
              end
            end else begin
              idx_q      <= idx_inc;
              out_word_q <= next_word;
              out_last_q <= !HAS_CSUM && (idx_inc == LAST_IDX);
            end
          end
        end
        CSUM: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_ready = !busy && rst_n;
  assign out_valid    = out_valid_q;
  assign out_word     = out_word_q;
  assign out_last     = out_last_q;
  assign drop_pulse   = drop_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_ln_result_serializer.sv
// Directed scoreboard bench for ln_result_serializer, with and without checksum.
module tb_ln_result_serializer;
  import ln_stream_pkg::*;

  localparam int DM   = 64;
  localparam int DW   = 16;
  localparam int MAXC = 400;

  typedef struct packed {
    word_t w;
    logic  last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rv_c, rv_n, rr_c, rr_n;
  logic [DM*DW-1:0]   rin_c, rin_n;
  logic               ov_c, ov_n, ol_c, ol_n;
  logic [DW-1:0]      ow_c, ow_n;
  logic               out_ready;
  logic               busy_c, busy_n, drop_c, drop_n;
  logic [7:0]         fc_c, fc_n;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   drop_seen;

  always #5 clk = ~clk;

  ln_result_serializer #(.D_MODEL(DM), .DATA_WIDTH(DW), .APPEND_CSUM(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .result_valid(rv_c), .result_in(rin_c),
    .result_ready(rr_c), .out_valid(ov_c), .out_word(ow_c), .out_last(ol_c),
    .out_ready(out_ready), .busy(busy_c), .drop_pulse(drop_c), .frame_cnt(fc_c)
  );

  ln_result_serializer #(.D_MODEL(DM), .DATA_WIDTH(DW), .APPEND_CSUM(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .result_valid(rv_n), .result_in(rin_n),
    .result_ready(rr_n), .out_valid(ov_n), .out_word(ow_n), .out_last(ol_n),
    .out_ready(out_ready), .busy(busy_n), .drop_pulse(drop_n), .frame_cnt(fc_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Offer a frame from posedge+1; pushes the expected words (and checksum).
  task automatic offer(input bit sel, input logic [DM*DW-1:0] v, output word_t csum);
    exp_t e;
    word_t acc;
    acc = '0;
    chk(sel ? "ready_n_idle" : "ready_c_idle", sel ? rr_n : rr_c, 1);
    for (int i = 0; i < DM; i++) begin
      e.w    = v[i*DW +: DW];
      e.last = sel && (i == DM - 1);
      acc    = acc + e.w;
      q.push_back(e);
    end
    if (!sel) begin
      e.w    = acc;
      e.last = 1'b1;
      q.push_back(e);
    end
    csum = acc;
    if (sel) begin rin_n = v; rv_n = 1'b1; end
    else     begin rin_c = v; rv_c = 1'b1; end
    @(posedge clk); #1;
    rv_c = 1'b0;
    rv_n = 1'b0;
  endtask

  // Consume words; mode 0 = ready always, mode 1 = ready on odd cycles.
  task automatic drain(input bit sel, input int mode, input int drop_at, input int stop_after,
                       input logic [DM*DW-1:0] junk, output int cycles, output word_t last_w);
    int    c = 0;
    int    hs = 0;
    bit    prev_rv = 0;
    bit    stalled = 0;
    bit    rdy;
    word_t pw;
    logic  pl;
    exp_t  e;
    logic  ov, ol, bz, rr;
    word_t ow;
    cycles = 0;
    last_w = '0;
    pw = '0;
    pl = 1'b0;
    drop_seen = 0;
    while (q.size() > 0 && hs < stop_after) begin
      if (c >= MAXC) begin
        chk("drain_timeout", q.size(), 0);
        break;
      end
      ov = sel ? ov_n : ov_c;
      ow = sel ? ow_n : ow_c;
      ol = sel ? ol_n : ol_c;
      bz = sel ? busy_n : busy_c;
      rr = sel ? rr_n : rr_c;
      chk("out_valid_held", ov, 1);
      chk("busy_streaming", bz, 1);
      chk("ready_low_busy", rr, 0);
      if (stalled) begin
        chk("stall_word", ow, pw);
        chk("stall_last", ol, pl);
      end
      if (!sel) begin
        chk("drop_pulse", drop_c, prev_rv);
        if (drop_c === 1'b1) drop_seen++;
        prev_rv = (drop_at >= 0) && (c >= drop_at) && (c < drop_at + 3);
        rv_c    = prev_rv;
        rin_c   = junk;
      end
      rdy = (mode == 0) ? 1'b1 : c[0];
      out_ready = rdy;
      if (rdy) begin
        e = q.pop_front();
        chk("word", ow, e.w);
        chk("last", ol, e.last);
        last_w  = ow;
        hs++;
        cycles  = c + 1;
        stalled = 0;
      end else begin
        stalled = 1;
        pw = ow;
        pl = ol;
      end
      @(posedge clk); #1;
      c++;
    end
    rv_c = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DM*DW-1:0] fa, ff, fb, fn, fr;
    word_t csum, last_w;
    int    cycles;

    for (int i = 0; i < DM; i++) begin
      fa[i*DW +: DW] = DW'(i);
      ff[i*DW +: DW] = 16'hFFFF;
      fb[i*DW +: DW] = DW'(16'hB000 + i * 5);
      fn[i*DW +: DW] = DW'(16'h1000 + i);
      fr[i*DW +: DW] = DW'(i * 37 + 11);
    end

    rst_n = 1'b0; rv_c = 1'b0; rv_n = 1'b0; out_ready = 1'b0;
    rin_c = '0; rin_n = '0;
    #1;
    chk("rst_out_valid", ov_c, 0);
    chk("rst_out_word", ow_c, 0);
    chk("rst_out_last", ol_c, 0);
    chk("rst_busy", busy_c, 0);
    chk("rst_drop", drop_c, 0);
    chk("rst_frame_cnt", fc_c, 0);
    chk("rst_ready_in_reset", rr_c, 0);
    chk("rst_n_out_valid", ov_n, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("ready_after_rst", rr_c, 1);
    @(posedge clk); #1;

    // 1: incrementing frame, ready always high
    offer(0, fa, csum);
    drain(0, 0, -1, 1000, fb, cycles, last_w);
    chk("t1_csum", last_w, 16'h07E0);
    chk("t1_cycles", cycles, 65);
    chk("t1_ready_back", rr_c, 1);
    chk("t1_valid_low", ov_c, 0);
    chk("t1_frame_cnt", fc_c, 1);

    // 2: same frame with ready toggling
    offer(0, fa, csum);
    drain(0, 1, -1, 1000, fb, cycles, last_w);
    chk("t2_csum", last_w, 16'h07E0);
    chk("t2_cycles", cycles, 130);
    chk("t2_frame_cnt", fc_c, 2);

    // 3: all-ones wrap
    offer(0, ff, csum);
    drain(0, 0, -1, 1000, fb, cycles, last_w);
    chk("t3_csum", last_w, 16'hFFC0);
    chk("t3_frame_cnt", fc_c, 3);

    // 4: frame B offered for 3 cycles while A streams
    offer(0, fa, csum);
    drain(0, 0, 10, 1000, fb, cycles, last_w);
    chk("t4_drop_count", drop_seen, 3);
    chk("t4_csum", last_w, 16'h07E0);
    chk("t4_frame_cnt", fc_c, 4);
    chk("t4_idle_after", ov_c, 0);
    repeat (2) @(posedge clk);
    #0 chk("t4_no_frame_b", ov_c, 0);
    @(posedge clk); #1;

    // 5: no checksum variant
    offer(1, fn, csum);
    drain(1, 0, -1, 1000, fb, cycles, last_w);
    chk("t5_last_word", last_w, 16'h103F);
    chk("t5_cycles", cycles, 64);
    chk("t5_valid_low", ov_n, 0);
    chk("t5_frame_cnt", fc_n, 1);

    // 6: reset in the middle of a frame
    offer(0, fr, csum);
    drain(0, 0, -1, 20, fb, cycles, last_w);
    chk("t6_word20_valid", ov_c, 1);
    chk("t6_cnt_before", fc_c, 4);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", ov_c, 0);
    chk("t6_busy_rst", busy_c, 0);
    chk("t6_cnt_rst", fc_c, 0);
    chk("t6_last_rst", ol_c, 0);
    chk("t6_ready_rst", rr_c, 0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    offer(0, fr, csum);
    drain(0, 0, -1, 1000, fb, cycles, last_w);
    chk("t6_fresh_csum", last_w, csum);
    chk("t6_cycles", cycles, 65);
    chk("t6_frame_cnt", fc_c, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ln_result_serializer.md
Name: ln_result_serializer

Overview:
- Downstream stage of the LayerNorm streaming path.
- Captures one complete D_MODEL x DATA_WIDTH flat result vector from the streaming controller's result_out/result_valid outputs.
- Emits the vector one word per handshake on a valid/ready word stream toward the SPI return path.
- Optionally appends a 16-bit additive checksum word and flags frames dropped because they arrived while busy.

Parameters:
- D_MODEL, 64, number of words per frame.
- DATA_WIDTH, 16, bits per word; checksum width equals DATA_WIDTH.
- APPEND_CSUM, 1, 1 = emit a checksum word after the data words; 0 = data words only.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- result_valid  input  1  frame-present strobe from the streaming controller
- result_in  input  D_MODEL*DATA_WIDTH  flat result vector; word i = result_in[i*DATA_WIDTH +: DATA_WIDTH]
- result_ready  output  1  high only in IDLE; a frame is accepted when result_valid && result_ready
- out_valid  output  1  out_word holds a valid word
- out_word  output  DATA_WIDTH  current output word
- out_last  output  1  marks the final word of the frame
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- busy  output  1  high whenever the state is not IDLE
- drop_pulse  output  1  one-cycle pulse: a frame was offered while busy and was discarded
- frame_cnt  output  8  count of fully transmitted frames; wraps 255 -> 0

Behaviour:
- Reset values (asynchronous, take effect immediately): state IDLE, out_valid 0, out_word 0, out_last 0, busy 0, drop_pulse 0, frame_cnt 0, word index 0, checksum accumulator 0. result_ready = 1 once reset is released.
- States:
  - IDLE: on accept, register result_in into a frame buffer, clear the index and accumulator, go to DATA.
  - DATA: out_valid=1, out_word = buffer word[idx]. On a handshake: accumulator += out_word (mod 2^DATA_WIDTH) and idx++. When the handshake is on idx=D_MODEL-1: go to CSUM if APPEND_CSUM, else go to IDLE and increment frame_cnt.
  - CSUM: out_valid=1, out_word = accumulator (includes all D_MODEL words), out_last=1. On a handshake go to IDLE and increment frame_cnt.
- Latency: accept in cycle N -> out_valid=1 with word 0 in cycle N+1. With out_ready held high, words are emitted on consecutive cycles. The frame occupies D_MODEL+APPEND_CSUM cycles, then one IDLE cycle before the next accept. Back-to-back frames are not supported.
- out_last = 1 only on the final word: the CSUM word, or word D_MODEL-1 when APPEND_CSUM=0.
- Stream rule: while out_valid && !out_ready, out_word and out_last are held stable and idx does not advance. out_valid never drops before its handshake.
- Output registers: out_valid, out_word and out_last are registered; out_word is the buffered word, with no combinational path from result_in.
- Drop: result_valid high in any non-IDLE cycle -> drop_pulse=1 in the next cycle, exactly one cycle per offending cycle. The frame in flight is unaffected. result_in is not sampled.
- Buffer: the frame buffer changes only on accept; input changes after accept are ignored.
- Arithmetic: checksum is an unsigned modulo-2^DATA_WIDTH sum of the raw word bits, with no saturation.
- Reset mid-frame: output drops immediately, the partial frame is lost and frame_cnt returns to 0.
- busy = (state != IDLE); result_ready = !busy && rst_n deasserted.

Decomposition:
- Shared package ln_stream_pkg: D_MODEL, DATA_WIDTH, word_t typedef, and the serializer state enum (IDLE, DATA, CSUM).
- No sub-module. The frame buffer plus index mux is a single always block; a separate buffer module adds nothing.

Test Plan:
1. Reset, then offer word i = i (i=0..63) with out_ready=1 -> accepted, 64 words 0x0000..0x003F on consecutive cycles, then checksum 0x07E0 with out_last=1; frame_cnt=1; result_ready returns high one cycle after the last handshake.
2. Same frame with out_ready toggling 1/0 every cycle -> identical word sequence. out_word is stable during each stall. Total of 130 cycles from first valid to last handshake.
3. All words 0xFFFF -> checksum 0xFFC0 (64*0xFFFF mod 2^16); verifies wrap with no saturation.
4. During streaming of frame A, pulse result_valid for 3 cycles with frame B -> drop_pulse high for 3 cycles, each delayed one cycle. Frame A output is unchanged and frame B never appears.
5. APPEND_CSUM=0, word i = 0x1000+i -> exactly 64 words, out_last on 0x103F, no checksum word.
6. Assert rst_n=0 at word 20 -> out_valid=0 and busy=0 immediately, frame_cnt=0. After release, a new frame streams from word 0 with a fresh checksum.
